// File: rtl/line_burst_adaptor.sv
// Converts one cache-line read/write-back request into a burst of s_burst-bit beats on the
// memory port, assembling read beats into line_o. LINE_ADAPTOR_PERF_EN adds perf counters.
module line_burst_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 8 * 2**s_offset,
  parameter int s_burst  = 64,
  parameter int n_beats  = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [s_burst-1:0] burst_o,
  input  logic [s_burst-1:0] burst_i,
  input  logic               resp_i
`ifdef LINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]        perf_rd_lines_o,
  output logic [31:0]        perf_wr_lines_o,
  output logic [31:0]        perf_wait_o
`endif
);

  localparam int CW = (n_beats > 2) ? $clog2(n_beats) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [s_line-1:0]   line_q, line_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         addr_aligned;
  logic                last_beat;
  logic                unused_addr_lsbs;

  assign addr_aligned     = {address_i[31:s_offset], {s_offset{1'b0}}};
  assign unused_addr_lsbs = ^address_i[s_offset-1:0];
  assign last_beat        = (count_q == CW'(n_beats - 1));
  assign line_o           = line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      line_q  <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      line_q  <= line_d;
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    line_d    = line_q;
    is_wr_d   = is_wr_q;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    address_o = '0;
    case (state_q)
      IDLE: begin
        // Write-back takes priority so a dirty victim leaves before the refill.
        if (write_i) begin
          state_d = WRITE;
          count_d = '0;
          is_wr_d = 1'b1;
        end else if (read_i) begin
          state_d = READ;
          count_d = '0;
          is_wr_d = 1'b0;
        end
      end
      READ: begin
        read_o    = 1'b1;
        address_o = addr_aligned;
        if (resp_i) begin
          line_d[count_q*s_burst +: s_burst] = burst_i;
          if (last_beat) state_d = DONE;
          else           count_d = count_q + 1'b1;
        end
      end
      WRITE: begin
        write_o   = 1'b1;
        address_o = addr_aligned;
        burst_o   = line_i[count_q*s_burst +: s_burst];
        if (resp_i) begin
          if (last_beat) state_d = DONE;
          else           count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        resp_o    = 1'b1;
        address_o = addr_aligned;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LINE_ADAPTOR_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q, perf_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd_q   <= '0;
      perf_wr_q   <= '0;
      perf_wait_q <= '0;
    end else begin
      if (state_q == DONE && !is_wr_q) perf_rd_q <= perf_rd_q + 32'd1;
      if (state_q == DONE &&  is_wr_q) perf_wr_q <= perf_wr_q + 32'd1;
      if ((state_q == READ || state_q == WRITE) && !resp_i)
        perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_rd_lines_o = perf_rd_q;
  assign perf_wr_lines_o = perf_wr_q;
  assign perf_wait_o     = perf_wait_q;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: scoreboard queues of expected lines/beats,
// immediate-assertion checks sampled on the falling edge.
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;
`ifdef LINE_ADAPTOR_PERF_EN
  logic [31:0]  perf_rd_lines_o;
  logic [31:0]  perf_wr_lines_o;
  logic [31:0]  perf_wait_o;
`endif

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int wait_cnt = 0;
  logic [255:0] last_line = '0;
  logic [255:0] exp_q[$];
  logic [63:0]  beat_q[$];

  line_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .line_i(line_i),
    .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o),
    .burst_i(burst_i), .resp_i(resp_i)
`ifdef LINE_ADAPTOR_PERF_EN
    ,
    .perf_rd_lines_o(perf_rd_lines_o),
    .perf_wr_lines_o(perf_wr_lines_o),
    .perf_wait_o(perf_wait_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [15:0] pat,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3);
    logic [255:0] exp_line;
    int nb;
    int i;
    exp_line = {b3, b2, b1, b0};
    exp_q.push_back(exp_line);
    address_i = addr;
    read_i    = 1'b1;
    @(negedge clk);
    chk("rd_address", 256'(address_o), 256'({addr[31:5], 5'b0}));
    nb = 0;
    i  = 0;
    while (nb < 4) begin
      chk("rd_read_o_high", 256'(read_o), 256'(1'b1));
      chk("rd_no_early_resp", 256'(resp_o), 256'(1'b0));
      resp_i = (i < 16) ? pat[i] : 1'b1;
      if (resp_i) begin
        burst_i = exp_line[nb*64 +: 64];
        nb++;
      end else begin
        burst_i = {$urandom, $urandom};
        wait_cnt++;
      end
      i++;
      @(negedge clk);
    end
    resp_i  = 1'b0;
    burst_i = '0;
    chk("rd_resp_o", 256'(resp_o), 256'(1'b1));
    chk("rd_read_o_done", 256'(read_o), 256'(1'b0));
    chk("rd_write_o_done", 256'(write_o), 256'(1'b0));
    last_line = exp_q.pop_front();
    chk("rd_line", line_o, last_line);
    read_i = 1'b0;
    rd_cnt++;
    @(negedge clk);
    chk("rd_resp_once", 256'(resp_o), 256'(1'b0));
    chk("rd_line_hold", line_o, last_line);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input logic [15:0] pat, input logic both);
    int nb;
    int i;
    for (int k = 0; k < 4; k++) beat_q.push_back(line[k*64 +: 64]);
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = both;
    @(negedge clk);
    chk("wr_address", 256'(address_o), 256'({addr[31:5], 5'b0}));
    nb = 0;
    i  = 0;
    while (nb < 4) begin
      chk("wr_write_o_high", 256'(write_o), 256'(1'b1));
      chk("wr_read_o_low", 256'(read_o), 256'(1'b0));
      chk("wr_burst_o", 256'(burst_o), 256'(beat_q[0]));
      resp_i = (i < 16) ? pat[i] : 1'b1;
      if (resp_i) begin
        beat_q.delete(0);
        nb++;
      end else begin
        wait_cnt++;
      end
      i++;
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("wr_resp_o", 256'(resp_o), 256'(1'b1));
    chk("wr_write_o_done", 256'(write_o), 256'(1'b0));
    chk("wr_read_o_done", 256'(read_o), 256'(1'b0));
    chk("wr_line_untouched", line_o, last_line);
    write_i = 1'b0;
    read_i  = 1'b0;
    wr_cnt++;
    @(negedge clk);
    chk("wr_resp_once", 256'(resp_o), 256'(1'b0));
  endtask

  initial begin
    rst       = 1'b1;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    #1;
    chk("rst_line_o", line_o, '0);
    chk("rst_resp_o", 256'(resp_o), '0);
    chk("rst_read_o", 256'(read_o), '0);
    chk("rst_write_o", 256'(write_o), '0);
    chk("rst_burst_o", 256'(burst_o), '0);
    chk("rst_address_o", 256'(address_o), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back beats, unaligned request address.
    do_read(32'h0000_1234, 16'hFFFF,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

    // Reset after two beats of a read.
    address_i = 32'h1000_0080;
    read_i    = 1'b1;
    @(negedge clk);
    resp_i  = 1'b1;
    burst_i = 64'hAAAA_0000_0000_0001;
    @(negedge clk);
    burst_i = 64'hAAAA_0000_0000_0002;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_read_o", 256'(read_o), '0);
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", 256'(address_o), '0);
    chk("midrst_resp_o", 256'(resp_o), '0);
    chk("midrst_write_o", 256'(write_o), '0);
    read_i  = 1'b0;
    resp_i  = 1'b0;
    burst_i = '0;
    last_line = '0;
    rd_cnt = 0;
    wr_cnt = 0;
    wait_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_resp", 256'(resp_o), '0);

    do_read(32'h1000_009F, 16'hFFFF,
            64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
            64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738);

    // Wait states interleaved: resp_i = 1,0,0,1,1,0,1.
    do_read(32'h0000_2000, 16'h0059,
            64'hA0A0_0000_0000_0000, 64'hB1B1_1111_0000_0000,
            64'hC2C2_2222_2222_0000, 64'hD3D3_3333_3333_3333);

    // resp_i while idle must be ignored.
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("idle_resp_no_read", 256'(read_o), '0);
    chk("idle_resp_no_done", 256'(resp_o), '0);
    chk("idle_resp_line", line_o, last_line);
    resp_i  = 1'b0;
    burst_i = '0;
    @(negedge clk);

    // Write-back with two wait states: resp_i = 0,1,0,1,1,1.
    do_write(32'h8000_0040,
             {64'hDEAD_DEAD_DEAD_DEAD, 64'h0123_4567_89AB_CDEF,
              64'hCAFE_F00D_CAFE_F00D, 64'h0000_0000_BEEF_BEEF},
             16'h003A, 1'b0);

    // Read and write requested together: write wins.
    do_write(32'h4000_1FFF,
             {64'h7777_6666_5555_4444, 64'h3333_2222_1111_0000,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5},
             16'hFFFF, 1'b1);

    do_read(32'hFFFF_FFE1, 16'hFFFF,
            64'h8000_0000_0000_0001, 64'h4000_0000_0000_0002,
            64'h2000_0000_0000_0004, 64'h1000_0000_0000_0008);

`ifdef LINE_ADAPTOR_PERF_EN
    chk("perf_rd_lines", 256'(perf_rd_lines_o), 256'(rd_cnt));
    chk("perf_wr_lines", 256'(perf_wr_lines_o), 256'(wr_cnt));
    chk("perf_wait", 256'(perf_wait_o), 256'(wait_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
